// File: rtl/srio_tx_arbiter.sv
// srio_tx_arbiter: round-robin arbiter that merges NUM_REQ AXI-stream
// sources into a single SRIO transmit stream. Each grant carries up to
// MAX_PKTS whole packets. A grant ends early when the grantee's
// "buffered" flag drops at a packet end.
// Optional feature: define SRIO_ARB_WATCHDOG_EN to abort a grant whose
// source stalls for WDOG_CYCLES cycles.
module srio_tx_arbiter #(
    parameter int DATA_WIDTH  = 64,
    parameter int NUM_REQ     = 4,
    parameter int MAX_PKTS    = 4,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_in,
    output logic [NUM_REQ-1:0]              fetch_data_out,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   s_tdata,
    input  logic [NUM_REQ-1:0]              s_tvalid,
    input  logic [NUM_REQ-1:0]              s_tlast,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0] s_tkeep,
    output logic [NUM_REQ-1:0]              s_tready,
    output logic [DATA_WIDTH-1:0]           m_tdata,
    output logic [DATA_WIDTH/8-1:0]         m_tkeep,
    output logic                            m_tvalid,
    output logic                            m_tlast,
    input  logic                            m_tready,
    output logic [2:0]                      grant_id_out,
    output logic                            busy,
    output logic                            timeout_err
);

    localparam int KEEP_WIDTH = DATA_WIDTH / 8;

    // Reject parameter values the 3-bit grant index and 8-bit packet
    // counter cannot represent.
    if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_PKTS < 1 || MAX_PKTS > 255 ||
        WDOG_CYCLES < 1 || WDOG_CYCLES > 65535) begin : g_param_check
        $error("srio_tx_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        RELEASE
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [2:0]              grant_id;
    logic [2:0]              last_grant;
    logic [2:0]              win_id;
    logic                    win_found;
    logic [7:0]              pkt_cnt;
    logic                    gnt_req;
    logic                    gnt_valid;
    logic                    gnt_last;
    logic [DATA_WIDTH-1:0]   gnt_data;
    logic [KEEP_WIDTH-1:0]   gnt_keep;
    logic                    pkt_end;
    logic                    grant_done;
    logic                    wdog_hit;

    // Round-robin pick: first requester at or after last_grant+1, with wrap.
    always_comb begin
        win_id    = 3'd0;
        win_found = 1'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!win_found && req_in[j] &&
                    (3'(j) == 3'((int'(last_grant) + off) % NUM_REQ))) begin
                    win_id    = 3'(j);
                    win_found = 1'b1;
                end
            end
        end
    end

    // Extract the granted requester's stream signals and buffered flag.
    always_comb begin
        gnt_req   = 1'b0;
        gnt_valid = 1'b0;
        gnt_last  = 1'b0;
        gnt_data  = '0;
        gnt_keep  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == 3'(i)) begin
                gnt_req   = req_in[i];
                gnt_valid = s_tvalid[i];
                gnt_last  = s_tlast[i];
                gnt_data  = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                gnt_keep  = s_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
            end
        end
    end

    assign pkt_end    = (state == XFER) && gnt_valid && gnt_last && m_tready;
    assign grant_done = (({1'b0, pkt_cnt} + 9'd1) == 9'(MAX_PKTS)) || !gnt_req;

    // Zero-latency stream mux; everything is quiet outside XFER.
    always_comb begin
        fetch_data_out = '0;
        s_tready       = '0;
        busy           = 1'b0;
        m_tdata        = '0;
        m_tkeep        = '0;
        m_tvalid       = 1'b0;
        m_tlast        = 1'b0;
        if (state == XFER) begin
            busy     = 1'b1;
            m_tdata  = gnt_data;
            m_tkeep  = gnt_keep;
            m_tvalid = gnt_valid;
            m_tlast  = gnt_last;
            for (int i = 0; i < NUM_REQ; i++) begin
                fetch_data_out[i] = (grant_id == 3'(i));
                s_tready[i]       = (grant_id == 3'(i)) && m_tready;
            end
        end
    end

    assign grant_id_out = grant_id;

    // Next-state logic: grants release only on packet boundaries or watchdog.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (win_found) state_next = XFER;
            XFER:    if (wdog_hit || (pkt_end && grant_done)) state_next = RELEASE;
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, grant bookkeeping and per-grant packet count.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            grant_id   <= 3'd0;
            last_grant <= 3'(NUM_REQ - 1);
            pkt_cnt    <= 8'd0;
        end else begin
            state <= state_next;
            if (state == IDLE && win_found) begin
                grant_id <= win_id;
            end
            if (state == RELEASE) begin
                last_grant <= grant_id;
                pkt_cnt    <= 8'd0;
            end else if (pkt_end) begin
                pkt_cnt <= pkt_cnt + 8'd1;
            end
        end
    end

`ifdef SRIO_ARB_WATCHDOG_EN
    logic [15:0] wdog_cnt;
    logic        timeout_q;

    assign wdog_hit    = (state == XFER) && !gnt_valid &&
                         (wdog_cnt == 16'(WDOG_CYCLES - 1));
    assign timeout_err = timeout_q;

    // Count consecutive stalled XFER cycles; the error pulse lines up with RELEASE.
    always_ff @(posedge clk) begin
        if (reset) begin
            wdog_cnt  <= 16'd0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= wdog_hit;
            if (state != XFER || gnt_valid || wdog_hit) begin
                wdog_cnt <= 16'd0;
            end else begin
                wdog_cnt <= wdog_cnt + 16'd1;
            end
        end
    end
`else
    assign wdog_hit    = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule
